video_timing_mixer: RTL and testbench
=====================================

// Module: video_timing_mixer
// PURPOSE
// Raster source and pixel sink for the sprite compositor: generates h/v counters and sync, drives
// pixel coordinates and v_sync to the compositor, takes back its RGB + sprite-hit, and muxes against
// a background colour into a registered video output (RGB, DE, HS, VS). One pixel per enabled clock.
// Also provides a frame counter and frame-start strobe for sprite motion logic.
// PARAMETERS
// H_ACTIVE   1920  visible pixels per line
// H_FP       88    horizontal front porch (pixels)
// H_SYNC     44    horizontal sync width (pixels)
// H_BP       148   horizontal back porch (pixels); H_TOTAL = sum of four = 2200
// V_ACTIVE   1080  visible lines;  V_FP 4, V_SYNC 5, V_BP 36 likewise; V_TOTAL = 1125
// HS_POL     1     output hsync active level;  VS_POL 1 output vsync active level
// BG_RGB     24'h000040  background colour {R,G,B} where sprite not hit
// PORTS
// i_clk         in   1   pixel clock
// i_rst_n       in   1   asynchronous active-low reset
// i_en          in   1   pixel enable; counters/pipeline advance only when high
// o_x           out  16  current h counter to compositor (combinational from counter reg)
// o_y           out  16  current v counter to compositor
// o_v_sync      out  1   raw vsync to compositor, active-high, same cycle as o_x/o_y
// i_red/i_green/i_blue in 8 each  compositor colour for (o_x,o_y); may be X when i_sprite_hit=0
// i_sprite_hit  in   1   compositor hit for (o_x,o_y), non-transparent sprite pixel
// o_red/o_green/o_blue out 8 each  registered output colour
// o_de          out  1   registered data enable (active area)
// o_hsync       out  1   registered hsync, polarity HS_POL
// o_vsync       out  1   registered vsync, polarity VS_POL
// o_frame       out  16  frame counter, wraps 16'hFFFF -> 0
// o_frame_start out  1   one-cycle pulse, registered, coincident with output pixel (0,0)
// BEHAVIOUR
// - Reset (async assert, sync deassert use): h=v=0, o_frame=0, o_frame_start=0, o_de=0,
//   RGB=0, o_hsync=~HS_POL, o_vsync=~VS_POL. Reset mid-frame restarts raster at (0,0).
// - Counters: on i_en, h<=h+1; at h==H_TOTAL-1: h<=0, v<=v+1 (v wraps V_TOTAL-1 -> 0).
//   i_en low: h, v, o_frame and all registered outputs hold; o_frame_start forced 0.
// - Active = (h<H_ACTIVE)&&(v<V_ACTIVE). Raw hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC);
//   raw vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). o_v_sync = raw vs (unregistered).
// - Compositor path is combinational; sample i_* in the same cycle o_x/o_y present.
// - Output stage, latency 1 enabled clock from counter value to o_*:
//   o_de<=active; o_hsync<=raw hs ^ ~HS_POL; o_vsync<=raw vs ^ ~VS_POL;
//   RGB <= !active ? 0 : i_sprite_hit ? {i_red,i_green,i_blue} : BG_RGB.
//   i_* colour never reaches outputs unless i_sprite_hit=1 and active (X must not propagate).
// - o_frame increments on enabled clock where h==H_TOTAL-1 && v==V_TOTAL-1.
// - o_frame_start registered high for exactly the enabled clock after counters are (0,0),
//   i.e. same cycle o_de first rises in a frame.
// - o_x/o_y valid in blanking too (compositor may hit there; output still blanked).
// - Widths: counters 16 bit; H_TOTAL,V_TOTAL must be <=65536 (elaboration check).
// TESTING
// - Reset: hold i_rst_n=0 -> all outputs at reset values above; release, i_en=1 -> o_x counts 0,1,2.
// - Line timing: run one line -> o_de high 1920 clks, o_hsync high clks 2009..2052 after line start
//   (registered, +1), line period 2200; frame period 2200*1125 = 2,475,000 clks.
// - Pixel mux: drive i_sprite_hit=1, RGB=FF/FF/00 when o_x=870,o_y=20 -> next clk o_red=FF,
//   o_green=FF, o_blue=00; hit=0 with RGB=X -> output 00/00/40, no X.
// - Blanking: i_sprite_hit=1 at o_x=1950 -> o_de=0, RGB=0.
// - Frame wrap: at (2199,1124) -> next (0,0), o_frame +1, o_frame_start pulses 1 clk; preload
//   65535 frames via force -> wraps to 0.
// - Enable/reset: i_en=0 for 10 clks mid-line -> o_x and outputs frozen; async reset mid-frame ->
//   outputs reset immediately, restart from (0,0).

Source files
------------

// File: rtl/video_timing_mixer.sv
// Raster timing generator and sprite/background pixel mixer.
// Drives coordinates to the compositor and registers the mixed video output.
module video_timing_mixer #(
    parameter int          H_ACTIVE = 1920,
    parameter int          H_FP     = 88,
    parameter int          H_SYNC   = 44,
    parameter int          H_BP     = 148,
    parameter int          V_ACTIVE = 1080,
    parameter int          V_FP     = 4,
    parameter int          V_SYNC   = 5,
    parameter int          V_BP     = 36,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter logic [23:0] BG_RGB   = 24'h000040
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_v_sync,
    input  logic [7:0]  i_red,
    input  logic [7:0]  i_green,
    input  logic [7:0]  i_blue,
    input  logic        i_sprite_hit,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_de,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic [15:0] o_frame,
    output logic        o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 16 bits wide, so neither total may exceed 2^16.
    if (H_TOTAL > 65536 || V_TOTAL > 65536) begin : g_size_check
        $error("video_timing_mixer: H_TOTAL/V_TOTAL exceed 16-bit counters");
    end

    // Bounds are 17 bits so an edge equal to 65536 still compares correctly.
    localparam logic [16:0] H_ACT_E  = 17'(H_ACTIVE);
    localparam logic [16:0] H_SYNC_S = 17'(H_ACTIVE + H_FP);
    localparam logic [16:0] H_SYNC_E = 17'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [16:0] V_ACT_E  = 17'(V_ACTIVE);
    localparam logic [16:0] V_SYNC_S = 17'(V_ACTIVE + V_FP);
    localparam logic [16:0] V_SYNC_E = 17'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);

    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic [15:0] frame_q, frame_d;
    logic [23:0] rgb_q, rgb_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;

    logic        active;
    logic        raw_hs;
    logic        raw_vs;
    logic        at_origin;

    // Decode the current raster position into active/sync flags.
    always_comb begin
        active    = ({1'b0, h_q} < H_ACT_E) && ({1'b0, v_q} < V_ACT_E);
        raw_hs    = ({1'b0, h_q} >= H_SYNC_S) && ({1'b0, h_q} < H_SYNC_E);
        raw_vs    = ({1'b0, v_q} >= V_SYNC_S) && ({1'b0, v_q} < V_SYNC_E);
        at_origin = (h_q == 16'd0) && (v_q == 16'd0);
    end

    // Advance h/v raster counters and the frame counter on enabled clocks.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (i_en) begin
            if (h_q == H_LAST) begin
                h_d = 16'd0;
                if (v_q == V_LAST) begin
                    v_d     = 16'd0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    v_d = v_q + 16'd1;
                end
            end else begin
                h_d = h_q + 16'd1;
            end
        end
    end

    // Mix compositor colour against background; blank outside the active area.
    always_comb begin
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        rgb_d = rgb_q;
        fs_d  = 1'b0;
        if (i_en) begin
            de_d = active;
            hs_d = raw_hs ^ ~HS_POL;
            vs_d = raw_vs ^ ~VS_POL;
            fs_d = at_origin;
            if (!active) begin
                rgb_d = 24'h000000;
            end else if (i_sprite_hit) begin
                rgb_d = {i_red, i_green, i_blue};
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    // State and output registers; reset restarts the raster at (0,0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_q     <= 16'd0;
            v_q     <= 16'd0;
            frame_q <= 16'd0;
            rgb_q   <= 24'h000000;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
            rgb_q   <= rgb_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

    assign o_x           = h_q;
    assign o_y           = v_q;
    assign o_v_sync      = raw_vs;
    assign o_red         = rgb_q[23:16];
    assign o_green       = rgb_q[15:8];
    assign o_blue        = rgb_q[7:0];
    assign o_de          = de_q;
    assign o_hsync       = hs_q;
    assign o_vsync       = vs_q;
    assign o_frame       = frame_q;
    assign o_frame_start = fs_q;

endmodule

// File: tb/tb_video_timing_mixer.sv
// Bench for video_timing_mixer using a reduced raster so whole frames fit.
// Reference model tracks a linear pixel index within the frame.
module tb_video_timing_mixer;

    localparam int HA = 16, HF = 3, HSW = 4, HB = 5;
    localparam int VA = 6, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FR = HT * VT;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam logic [23:0] BG = 24'h000040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        hit = 1'b0;
    logic [7:0]  r = 8'h00, g = 8'h00, b = 8'h00;
    logic [15:0] o_x, o_y, o_frame;
    logic        o_v_sync, o_de, o_hsync, o_vsync, o_frame_start;
    logic [7:0]  o_red, o_green, o_blue;

    video_timing_mixer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .BG_RGB(BG)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .o_x(o_x), .o_y(o_y), .o_v_sync(o_v_sync),
        .i_red(r), .i_green(g), .i_blue(b), .i_sprite_hit(hit),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_frame(o_frame), .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    // model state
    int          pos;
    logic [15:0] mframe;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [23:0] e_rgb;

    typedef struct {
        int          x;
        int          y;
        logic        hit;
        logic [23:0] c;
        logic        de;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        pos    = 0;
        mframe = 16'd0;
        e_de   = 1'b0;
        e_hs   = ~HSP;
        e_vs   = ~VSP;
        e_fs   = 1'b0;
        e_rgb  = 24'h0;
    endtask

    task automatic check_outs();
        chk("o_de", o_de, e_de);
        chk("o_hsync", o_hsync, e_hs);
        chk("o_vsync", o_vsync, e_vs);
        chk("o_rgb", {o_red, o_green, o_blue}, e_rgb);
        chk("o_frame", o_frame, mframe);
        chk("o_frame_start", o_frame_start, e_fs);
    endtask

    task automatic step(input logic e, input logic h, input logic [23:0] c);
        int   x, y;
        logic act;
        @(negedge clk);
        en  = e;
        hit = h;
        if (h) {r, g, b} = c;
        else {r, g, b} = 24'hxxxxxx;
        x = pos % HT;
        y = pos / HT;
        chk("o_x", o_x, 32'(x));
        chk("o_y", o_y, 32'(y));
        chk("o_v_sync", o_v_sync, 32'(y >= VA + VF && y < VA + VF + VSW));
        if (e) begin
            act   = (x < HA) && (y < VA);
            e_de  = act;
            e_hs  = (x >= HA + HF && x < HA + HF + HSW) ? HSP : ~HSP;
            e_vs  = (y >= VA + VF && y < VA + VF + VSW) ? VSP : ~VSP;
            e_rgb = !act ? 24'h0 : (h ? c : BG);
            e_fs  = (pos == 0);
            pos   = (pos + 1) % FR;
            if (pos == 0) mframe = mframe + 16'd1;
        end else begin
            e_fs = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic seek(input int target);
        int n;
        n = 0;
        while (pos != target && n < 2 * FR) begin
            step(1'b1, 1'b0, 24'h0);
            n++;
        end
        chk("seek", pos, target);
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first;

        tbl[0] = '{3,  1, 1'b1, 24'hFFFF00, 1'b1, 24'hFFFF00};
        tbl[1] = '{4,  1, 1'b0, 24'h000000, 1'b1, 24'h000040};
        tbl[2] = '{17, 1, 1'b1, 24'h123456, 1'b0, 24'h000000};
        tbl[3] = '{2,  7, 1'b1, 24'hABCDEF, 1'b0, 24'h000000};
        tbl[4] = '{15, 5, 1'b1, 24'h010203, 1'b1, 24'h010203};
        tbl[5] = '{0,  6, 1'b1, 24'h0A0B0C, 1'b0, 24'h000000};
        tbl[6] = '{0,  0, 1'b1, 24'hAA55AA, 1'b1, 24'hAA55AA};

        // reset held
        mreset();
        repeat (3) @(posedge clk);
        #1;
        check_outs();
        chk("rst_x", o_x, 0);
        chk("rst_y", o_y, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // o_x counts 0,1,2 after release
        repeat (3) step(1'b1, 1'b0, 24'h0);
        chk("count_x", o_x, 3);

        // line timing on line 1
        seek(HT);
        de_cnt = 0; hs_cnt = 0; hs_first = -1;
        for (int k = 0; k < HT; k++) begin
            step(1'b1, 1'b0, 24'h0);
            if (o_de) de_cnt++;
            if (o_hsync == HSP) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
        end
        chk("line_de_cnt", de_cnt, HA);
        chk("line_hs_cnt", hs_cnt, HSW);
        chk("line_hs_first", hs_first, HA + HF);
        chk("line_period", pos, 2 * HT);

        // pixel mux table
        for (int i = 0; i < 7; i++) begin
            seek(tbl[i].y * HT + tbl[i].x);
            step(1'b1, tbl[i].hit, tbl[i].c);
            chk("tbl_de", o_de, tbl[i].de);
            chk("tbl_rgb", {o_red, o_green, o_blue}, tbl[i].rgb);
        end

        // enable low mid-line
        seek(2 * HT + 7);
        repeat (10) step(1'b0, 1'b1, 24'h777777);
        chk("freeze_x", o_x, 7);
        chk("freeze_y", o_y, 2);
        step(1'b1, 1'b0, 24'h0);
        chk("resume_x", o_x, 8);

        // frame wrap from 65535
        seek(FR - 1);
        force dut.frame_q = 16'hFFFF;
        #1;
        release dut.frame_q;
        mframe = 16'hFFFF;
        step(1'b1, 1'b0, 24'h0);
        chk("wrap_frame", o_frame, 0);
        chk("wrap_xy", {o_x, o_y}, 0);
        step(1'b1, 1'b1, 24'h102030);
        chk("wrap_fs", o_frame_start, 1);
        chk("wrap_de", o_de, 1);
        step(1'b1, 1'b0, 24'h0);
        chk("wrap_fs_off", o_frame_start, 0);

        // random stimulus
        for (int i = 0; i < 900; i++) begin
            step(($urandom_range(0, 9) != 0), $urandom_range(0, 1),
                 24'($urandom));
        end

        // async reset mid-frame
        seek(3 * HT + 5);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mreset();
        check_outs();
        chk("arst_x", o_x, 0);
        chk("arst_y", o_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0, 24'h0);
        chk("arst_restart_x", o_x, 3);
        seek(0);
        step(1'b1, 1'b0, 24'h0);
        chk("arst_frame", o_frame, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
